// File: rtl/sha_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha_pkg                                                              |
// | Shared SHA-256 types: hash state, block window, loader FSM states.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sha_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } hash_state_t;

    // Index 0 holds the first word received
    typedef logic [15:0][31:0] block_t;

    localparam hash_state_t SHA256_IV = '{
        a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
        e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
    };

    typedef enum logic [1:0] {
        ST_FILL       = 2'd0,
        ST_WAIT_CHAIN = 2'd1,
        ST_ISSUE      = 2'd2
    } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/sha_block_window.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha_block_window                                                     |
// | 16x32 message window, written one word at a time at index idx.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sha_block_window
    import sha_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  idx,
    input  logic [31:0] data,
    output block_t      window
);

    block_t r_window;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_window <= '0;
        end else if (we) begin
            r_window[idx] <= data;
        end
    end

    assign window = r_window;

endmodule
`default_nettype wire

// File: rtl/sha_block_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sha_block_loader                                                     |
// | Assembles 16-word blocks and issues them with IV or chained state.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sha_block_loader
    import sha_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    input  logic        msg_start_i,
    input  hash_state_t chain_i,
    input  logic        chain_valid_i,
    output hash_state_t state_o,
    output block_t      W_o,
    output logic        valid_o,
    output logic        newblock_o
);

    loader_state_t r_state;
    loader_state_t w_state_next;
    logic          w_go_issue;
    logic [3:0]    r_count;
    logic          r_blk_start;
    logic          r_chain_pend;
    hash_state_t   r_chain;
    block_t        w_window;
    block_t        w_window_next;
    logic          w_accept;
    logic          w_last;

    hash_state_t   r_state_out;
    block_t        r_w_out;
    logic          r_valid;
    logic          r_newblock;

    assign word_ready_o = (r_state == ST_FILL);
    assign w_accept     = word_valid_i && word_ready_o;
    assign w_last       = w_accept && (r_count == 4'd15);

    sha_block_window u_window (
        .clk    (clk),
        .rst    (rst),
        .we     (w_accept),
        .idx    (r_count),
        .data   (word_i),
        .window (w_window)
    );

    // Word 15 lands in the window on the same edge the outputs load, so merge it here
    always_comb begin
        w_window_next = w_window;
        if (w_accept) begin
            w_window_next[r_count] = word_i;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_go_issue   = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_last) begin
                    if (r_blk_start || r_chain_pend || chain_valid_i) begin
                        w_state_next = ST_ISSUE;
                        w_go_issue   = 1'b1;
                    end else begin
                        w_state_next = ST_WAIT_CHAIN;
                    end
                end
            end
            ST_WAIT_CHAIN: begin
                if (chain_valid_i || r_chain_pend) begin
                    w_state_next = ST_ISSUE;
                    w_go_issue   = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_FILL;
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_FILL;
            r_count      <= 4'd0;
            r_blk_start  <= 1'b0;
            r_chain_pend <= 1'b0;
            r_chain      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_count <= r_count + 4'd1;
            end
            if (w_accept && (r_count == 4'd0)) begin
                r_blk_start <= msg_start_i;
            end
            // A fresh chain pulse outranks consumption by an issuing block
            if (chain_valid_i) begin
                r_chain      <= chain_i;
                r_chain_pend <= 1'b1;
            end else if ((r_state == ST_ISSUE) && !r_blk_start) begin
                r_chain_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_out <= '0;
            r_w_out     <= '0;
            r_valid     <= 1'b0;
            r_newblock  <= 1'b0;
        end else begin
            r_valid <= w_go_issue;
            if (w_go_issue) begin
                r_w_out    <= w_window_next;
                r_newblock <= r_blk_start;
                if (r_blk_start) begin
                    r_state_out <= SHA256_IV;
                end else if (chain_valid_i) begin
                    r_state_out <= chain_i;
                end else begin
                    r_state_out <= r_chain;
                end
            end
        end
    end

    assign state_o    = r_state_out;
    assign W_o        = r_w_out;
    assign valid_o    = r_valid;
    assign newblock_o = r_newblock;

endmodule
`default_nettype wire
